// File: rtl/crossbar_pkg.sv
// rtl/crossbar_pkg.sv - shared constants, state encoding and helpers for the crossbar route scheduler
package crossbar_pkg;

    localparam int CTRL_W = 5;
    localparam int SEL_W  = 2;
    localparam int MAP_W  = 4 * SEL_W;

    localparam logic [MAP_W-1:0]  IDENTITY_MAP  = 8'hE4;
    localparam logic [CTRL_W-1:0] CTRL_IDENTITY = 5'b00000;
    localparam logic [CTRL_W-1:0] CTRL_LAST     = 5'b11111;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

    // A request is only routable if every output selects a different input.
    function automatic logic is_perm(input logic [MAP_W-1:0] m);
        logic [SEL_W-1:0] s0, s1, s2, s3;
        s0 = m[1:0];
        s1 = m[3:2];
        s2 = m[5:4];
        s3 = m[7:6];
        return (s0 != s1) && (s0 != s2) && (s0 != s3) &&
               (s1 != s2) && (s1 != s3) && (s2 != s3);
    endfunction

endpackage

// File: rtl/crossbar_route_sched_if.sv
// rtl/crossbar_route_sched_if.sv - request/control bundle between requester and route scheduler
interface crossbar_route_sched_if;
    import crossbar_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [MAP_W-1:0]      req_map;
    logic [CTRL_W-1:0]     control;
    logic                  done;
    logic                  err;
    logic                  busy;

    modport master (
        output req_valid,
        output req_map,
        input  req_ready,
        input  control,
        input  done,
        input  err,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_map,
        output req_ready,
        output control,
        output done,
        output err,
        output busy
    );

endinterface

// File: rtl/crossbar_route_model.sv
// rtl/crossbar_route_model.sv - combinational tag propagation through the fixed 5-switch 4x4 network
module crossbar_route_model
    import crossbar_pkg::*;
(
    input  logic [CTRL_W-1:0] control,
    output logic [MAP_W-1:0]  map
);

    logic [SEL_W-1:0] a, b, c, d, e, f;
    logic [SEL_W-1:0] o1, o2, o3, o4;

    // Each switch passes (upper->upper) when its bit is 0 and crosses when 1.
    always_comb begin
        a  = control[0] ? 2'd1 : 2'd0;
        b  = control[0] ? 2'd0 : 2'd1;
        c  = control[1] ? 2'd3 : 2'd2;
        d  = control[1] ? 2'd2 : 2'd3;
        e  = control[2] ? c : b;
        f  = control[2] ? b : c;
        o1 = control[3] ? e : a;
        o2 = control[3] ? a : e;
        o3 = control[4] ? d : f;
        o4 = control[4] ? f : d;
        map = {o4, o3, o2, o1};
    end

endmodule

// File: rtl/crossbar_route_sched.sv
// rtl/crossbar_route_sched.sv - searches switch settings one per clock and holds the first match
module crossbar_route_sched
    import crossbar_pkg::*;
#(
    parameter int FAST_REPEAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    crossbar_route_sched_if.slave    bus
);

    state_t              state;
    state_t              state_next;
    logic [CTRL_W-1:0]   counter;
    logic [CTRL_W-1:0]   control_q;
    logic [MAP_W-1:0]    req_q;
    logic [MAP_W-1:0]    last_map;
    logic                done_q;
    logic                err_q;
    logic [MAP_W-1:0]    cand_map;
    logic                accept;
    logic                req_perm;
    logic                req_repeat;
    logic                cand_match;

    crossbar_route_model u_model (
        .control (counter),
        .map     (cand_map)
    );

    assign accept     = bus.req_valid && (state == ST_IDLE);
    assign req_perm   = is_perm(bus.req_map);
    assign req_repeat = (FAST_REPEAT != 0) && (bus.req_map == last_map);
    assign cand_match = (cand_map == req_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only a well-formed, non-repeated request starts a search.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && req_perm && !req_repeat) begin
                    state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (cand_match || (counter == CTRL_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        bus.req_ready = (state == ST_IDLE);
        bus.busy      = (state == ST_SEARCH);
    end

    // Datapath: candidate counter, held control word, last routed map and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= '0;
            control_q <= CTRL_IDENTITY;
            req_q     <= IDENTITY_MAP;
            last_map  <= IDENTITY_MAP;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!req_perm) begin
                            err_q <= 1'b1;
                        end else if (req_repeat) begin
                            done_q <= 1'b1;
                        end else begin
                            req_q   <= bus.req_map;
                            counter <= '0;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (cand_match) begin
                        control_q <= counter;
                        last_map  <= req_q;
                        done_q    <= 1'b1;
                    end else if (counter == CTRL_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.control = control_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_crossbar_route_sched.sv
// tb/tb_crossbar_route_sched.sv - randomized self-checking bench for crossbar_route_sched
module tb_crossbar_route_sched;
    import crossbar_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [CTRL_W-1:0] exp_ctrl;
    logic [MAP_W-1:0]  exp_last;
    logic [MAP_W-1:0]  chk_map;

    crossbar_route_sched_if bus ();

    crossbar_route_sched #(.FAST_REPEAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    crossbar_route_model u_chk (
        .control (bus.control),
        .map     (chk_map)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Table-driven network: nets 0..3 are inputs, 4..9 are a..f, 10..13 are out1..out4.
    function automatic logic [MAP_W-1:0] ref_route(input int ctrl);
        int net [14];
        int up_in [5] = '{0, 2, 5, 4, 9};
        int lo_in [5] = '{1, 3, 6, 8, 7};
        int up_o  [5] = '{4, 6, 8, 10, 12};
        int lo_o  [5] = '{5, 7, 9, 11, 13};
        logic [MAP_W-1:0] m;
        for (int i = 0; i < 4; i++) net[i] = i;
        for (int s = 0; s < 5; s++) begin
            if (((ctrl >> s) & 1) == 1) begin
                net[up_o[s]] = net[lo_in[s]];
                net[lo_o[s]] = net[up_in[s]];
            end else begin
                net[up_o[s]] = net[up_in[s]];
                net[lo_o[s]] = net[lo_in[s]];
            end
        end
        m = '0;
        for (int o = 0; o < 4; o++) m = m | (MAP_W'(net[10 + o]) << (2 * o));
        return m;
    endfunction

    function automatic bit ref_distinct(input logic [MAP_W-1:0] m);
        bit seen [4];
        for (int i = 0; i < 4; i++) seen[i] = 0;
        for (int o = 0; o < 4; o++) begin
            if (seen[(m >> (2 * o)) & 3]) return 0;
            seen[(m >> (2 * o)) & 3] = 1;
        end
        return 1;
    endfunction

    // Issue one request and compare edge timing, pulses, busy time and held control with the model.
    task automatic send_req(input logic [MAP_W-1:0] m);
        int w, exp_done, exp_err, exp_busy, found;
        int got_done, got_err, busy_cnt, pulse_cnt, glitch;
        logic [CTRL_W-1:0] ctrl_before;
        w = 0;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", 32'(w < 100), 32'd1);
        exp_done = 0; exp_err = 0; exp_busy = 0; found = -1;
        if (!ref_distinct(m)) begin
            exp_err = 1;
        end else if (m == exp_last) begin
            exp_done = 1;
        end else begin
            for (int k = 0; k < 32 && found < 0; k++) if (ref_route(k) == m) found = k;
            if (found >= 0) begin
                exp_done = found + 2;
                exp_busy = found + 1;
            end else begin
                exp_err  = 33;
                exp_busy = 32;
            end
        end
        bus.req_valid = 1'b1;
        bus.req_map   = m;
        ctrl_before = bus.control;
        got_done = 0; got_err = 0; busy_cnt = 0; pulse_cnt = 0; glitch = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) bus.req_valid = 1'b0;
            if (bus.done && got_done == 0) got_done = n;
            if (bus.err && got_err == 0) got_err = n;
            pulse_cnt += int'(bus.done) + int'(bus.err);
            if (bus.busy) busy_cnt++;
            if (!bus.done && bus.control !== ctrl_before) glitch = 1;
            if (bus.done) ctrl_before = bus.control;
        end
        if (found >= 0) begin
            exp_ctrl = CTRL_W'(found);
            exp_last = m;
        end
        check($sformatf("done_edge[%02h]", m), 32'(got_done), 32'(exp_done));
        check($sformatf("err_edge[%02h]", m), 32'(got_err), 32'(exp_err));
        check($sformatf("busy_cycles[%02h]", m), 32'(busy_cnt), 32'(exp_busy));
        check($sformatf("pulse_count[%02h]", m), 32'(pulse_cnt), 32'd1);
        check($sformatf("ctrl_stable[%02h]", m), 32'(glitch), 32'd0);
        check($sformatf("control[%02h]", m), 32'(bus.control), 32'(exp_ctrl));
        if (exp_done != 0) check($sformatf("realised[%02h]", m), 32'(chk_map), 32'(m));
    endtask

    initial begin
        int perm [4];
        logic [MAP_W-1:0] m;
        bus.req_valid = 1'b0;
        bus.req_map   = '0;
        exp_ctrl = 5'd0;
        exp_last = 8'hE4;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_control", 32'(bus.control), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        send_req(8'hE4);
        send_req(8'hE1);
        check("e1_control", 32'(bus.control), 32'd1);
        send_req(8'h1B);
        send_req(8'h00);

        // Reset while searching an unroutable request with candidate 10 under evaluation.
        bus.req_valid = 1'b1;
        bus.req_map   = 8'h1B;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_control", 32'(bus.control), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ctrl = 5'd0;
        exp_last = 8'hE4;
        @(negedge clk);
        check("post_rst_pulse", 32'(bus.done | bus.err), 32'd0);

        // All 24 permutations.
        for (int p0 = 0; p0 < 4; p0++)
            for (int p1 = 0; p1 < 4; p1++)
                for (int p2 = 0; p2 < 4; p2++)
                    if (p0 != p1 && p0 != p2 && p1 != p2) begin
                        m = MAP_W'(p0 | (p1 << 2) | (p2 << 4) | ((6 - p0 - p1 - p2) << 6));
                        send_req(m);
                    end

        // Random mix of shuffled permutations and raw bytes.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) perm[i] = i;
                for (int i = 3; i > 0; i--) begin
                    int j, t;
                    j = int'($urandom_range(0, i));
                    t = perm[i]; perm[i] = perm[j]; perm[j] = t;
                end
                m = MAP_W'(perm[0] | (perm[1] << 2) | (perm[2] << 4) | (perm[3] << 6));
            end else begin
                m = MAP_W'($urandom);
            end
            send_req(m);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/crossbar_route_sched.md
Name: crossbar_route_sched

Overview:
Control-word generator that sits directly upstream of the 4x4 4-bit crossbar. It accepts an output-to-input permutation request and searches the 32 possible 5-bit switch settings, one candidate per clock. It latches the first (lowest) control word that realises the request and holds it on the crossbar's 5-bit control input until the next successful request. Unroutable or malformed requests are rejected with an error pulse, and the held control word is left untouched.

Parameters:
CTRL_W, 5, number of 2x2 switches / control bits (fixed for the 4x4 network)
SEL_W, 2, bits per output select field
FAST_REPEAT, 1, when 1 a request identical to the last routed map completes without searching

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request strobe
req_ready  out  1  block can accept a request (high in IDLE only)
req_map  in  8  [1:0]=input index driving out1, [3:2]=out2, [5:4]=out3, [7:6]=out4 (0=in1..3=in4)
control  out  5  switch settings to crossbar; bit i drives switch s<i>; 0=pass, 1=cross
done  out  1  one-cycle pulse: control updated to a matching word
err  out  1  one-cycle pulse: request rejected (duplicate select or no route)
busy  out  1  high while in SEARCH

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, control=5'b00000 (identity), done=0, err=0, busy=0, req_ready=1, last-map register=8'hE4 (identity), candidate counter=0. Reset mid-search aborts the search; no done/err pulse is issued.
- Network model (fixed topology): s0(in1,in2)->a,b. s1(in3,in4)->c,d. s2(b,c)->e,f. s3(a,e)->out1,out2. s4(f,d)->out3,out4. A pass switch maps upper->upper and lower->lower; cross swaps them. Tags (input indices) propagate through the model combinationally.
- States: IDLE, SEARCH.
- IDLE: accept on req_valid & req_ready.
  - If the four selects are not a permutation (any duplicate): next edge err=1, stay IDLE.
  - Else if FAST_REPEAT and req_map==last map: next edge done=1, control unchanged.
  - Else latch req_map, counter<=0, go SEARCH.
- SEARCH: each cycle evaluates candidate=counter through the model.
  - Match: next edge control<=counter, last map<=request, done=1, go IDLE.
  - Else if counter==31: next edge err=1, control unchanged, go IDLE.
  - Else counter+1.
- Latency: a match at candidate k gives done k+2 edges after the accept edge. A no-route result gives err 33 edges after accept.
- Requests are ignored while busy; req_ready=0 in SEARCH. done and err are never high together. Both are 0 in every cycle other than their pulse.
- control changes only on reset or on a done caused by a search. It is stable at all other times, including during SEARCH.

Decomposition:
- Shared package crossbar_pkg: CTRL_W, SEL_W, IDENTITY_MAP=8'hE4, CTRL_IDENTITY=5'b00000, state encoding for IDLE/SEARCH.
- One combinational sub-module, crossbar_route_model: inputs control[4:0]; outputs 8-bit realised map in req_map layout. The bench reuses it as a reference model.

Test Plan:
1. Reset then req_map=8'hE4 with FAST_REPEAT=1 -> done one edge after accept; control stays 5'b00000; no search (busy never 1).
2. req_map=8'hE1 (out1=in2, out2=in1, out3=in3, out4=in4) -> busy for 2 cycles; done 3 edges after accept; control=5'b00001.
3. Reversal req_map=8'h1B -> err pulse 33 edges after accept; control keeps its prior value; done stays 0.
4. Duplicate req_map=8'h00 -> err one edge after accept; no SEARCH entered; control unchanged.
5. Assert rst during SEARCH for an unroutable request at candidate 10 -> next edge control=0, state IDLE, no done/err pulse; req_ready=1.
6. Exhaustive: all 24 permutations in turn -> each yields done with control equal to the lowest word whose model output matches, or err if none; control checked against crossbar_route_model.
